phy_rx_destripe: RTL and testbench
==================================

PHY_RX_DESTRIPE -- requirements
Module: phy_rx_destripe

Interface
REQ-001 Parameter COM_SYM, default 8'hBC, alignment (COM) symbol value.
REQ-002 Parameter LANES_W, default 2, width of the lane index; the lane count is fixed at 4 and LANES_W SHALL NOT be overridden.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 reset_L  input  1  reset, synchronous, active-low.
REQ-005 data_in  input  8  serial byte stream from the PHY TX striper.
REQ-006 valid_in  input  1  data_in qualifier; a byte is accepted only on an edge where valid_in=1.
REQ-007 data_out0..data_out3  output  8 each  de-striped lane bytes 0..3, registered.
REQ-008 valid_out  output  1  one-cycle pulse; data_out0..3 hold a complete group.
REQ-009 aligned  output  1  high while the FSM is in ALIGNED.
REQ-010 align_err  output  1  one-cycle pulse on a misaligned COM (only when PHY_RX_COM_STRIP_EN is defined).

Function
REQ-011 The FSM SHALL have two states: SEARCH (encoding 0) and ALIGNED (encoding 1).
REQ-012 In SEARCH, an accepted byte equal to COM_SYM SHALL move the FSM to ALIGNED with lane_idx=0 and SHALL be discarded.
REQ-013 In SEARCH, all other accepted bytes SHALL be discarded, with no output change.
REQ-014 In ALIGNED, each accepted data byte SHALL be stored in the lane register lane_idx and lane_idx SHALL increment modulo 4.
REQ-015 An edge with valid_in=0 SHALL not change lane_idx or the stored bytes (pause, not abort).
REQ-016 When the byte for lane 3 is accepted at edge N, valid_out SHALL be 1 after edge N for exactly one cycle.
REQ-017 After that edge, data_out0..3 SHALL present the 4 bytes of the group in arrival order (first byte on lane 0).
REQ-018 data_out0..3 SHALL hold their values until the next completed group.
REQ-019 Back-to-back groups with valid_in held high SHALL produce valid_out every 4th cycle with no bubble.
REQ-020 The latency from accepting the lane-3 byte to valid_out SHALL be 1 cycle.
REQ-021 aligned SHALL equal 1 exactly when the state is ALIGNED.
REQ-022 A partial group SHALL never raise valid_out.

Reset
REQ-023 With reset_L=0 at an edge, after that edge: state=SEARCH, lane_idx=0, data_out0..3=8'h00, valid_out=0, aligned=0, align_err=0.
REQ-024 Reset SHALL take priority over any accepted byte on the same edge.
REQ-025 Reset asserted mid-group SHALL discard the partial group, and no valid_out SHALL follow reset.
REQ-026 After reset_L returns high, a new COM SHALL be required before any output.

Configuration
REQ-027 The configuration macro SHALL be PHY_RX_COM_STRIP_EN.
REQ-028 With PHY_RX_COM_STRIP_EN defined: in ALIGNED, an accepted COM_SYM SHALL be discarded and SHALL reset lane_idx to 0.
REQ-029 With PHY_RX_COM_STRIP_EN defined, a COM_SYM accepted with lane_idx!=0 SHALL drop the partial group and pulse align_err for one cycle.
REQ-030 With PHY_RX_COM_STRIP_EN defined, a COM_SYM accepted with lane_idx=0 SHALL be discarded silently.
REQ-031 Without PHY_RX_COM_STRIP_EN: in ALIGNED, COM_SYM SHALL be treated as ordinary data.
REQ-032 Without PHY_RX_COM_STRIP_EN, align_err SHALL be tied to 0.

Verification
REQ-033 Reset, then BC,01,02,03,04 with valid_in=1 -> one cycle after the 04 byte: valid_out=1, data_out0..3=01,02,03,04, aligned=1.
REQ-034 Stream 11,22 before any BC -> no valid_out, aligned=0; after BC,AA,BB,CC,DD -> data_out=AA,BB,CC,DD.
REQ-035 BC,01,02, then valid_in=0 for 3 cycles, then 03,04 -> a single valid_out with 01,02,03,04.
REQ-036 With PHY_RX_COM_STRIP_EN defined: BC,01,02,BC,05,06,07,08 -> align_err pulse after the second BC, then one valid_out with 05,06,07,08.
REQ-037 Without PHY_RX_COM_STRIP_EN: BC,01,BC,03,04 -> data_out=01,BC,03,04, align_err stays 0.
REQ-038 BC,01,02 then reset_L=0 for one cycle then 03,04,05,06 -> no valid_out until a new BC is received.

Source files
------------

// File: rtl/phy_rx_destripe.sv
// -----------------------------------------------------------------------------
// phy_rx_destripe
//
// Purpose:
//   Receive-side de-striper. The PHY TX striper serialises each 4-byte group
//   onto an 8-bit stream, with an alignment (COM) symbol marking the group
//   boundary. This block hunts for the first COM (SEARCH). It then collects
//   bytes into lanes 0..3 (ALIGNED) and presents each complete group for one
//   cycle on data_out0..3 / valid_out.
//
// Optional feature (macro PHY_RX_COM_STRIP_EN):
//   When defined, a COM seen while ALIGNED re-aligns the lane counter and is
//   stripped from the stream. If it arrives mid-group, the partial group is
//   dropped and align_err pulses. When undefined, a COM seen while ALIGNED is
//   ordinary data and align_err is tied low.
//
// Ports:
//   clk          in   rising-edge clock
//   reset_L      in   synchronous active-low reset
//   data_in      in   8-bit serial byte stream
//   valid_in     in   data_in qualifier (low = pause, state is held)
//   data_out0..3 out  registered de-striped lane bytes (held between groups)
//   valid_out    out  one-cycle pulse when data_out0..3 hold a new group
//   aligned      out  high while the FSM is in ALIGNED
//   align_err    out  one-cycle pulse on a mid-group COM (feature only)
// -----------------------------------------------------------------------------
module phy_rx_destripe #(
    parameter logic [7:0] COM_SYM = 8'hBC,
    // Lane count is fixed at 4; this width must stay at 2.
    parameter int         LANES_W = 2
) (
    input  logic       clk,
    input  logic       reset_L,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic [7:0] data_out0,
    output logic [7:0] data_out1,
    output logic [7:0] data_out2,
    output logic [7:0] data_out3,
    output logic       valid_out,
    output logic       aligned,
    output logic       align_err
);

    localparam int LANES = 4;

    typedef enum logic {
        SEARCH  = 1'b0,
        ALIGNED = 1'b1
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [LANES_W-1:0] lane_idx_reg;
    logic [7:0]         stage_reg [0:LANES-2];
    logic [7:0]         out_reg   [0:LANES-1];
    logic               valid_out_reg;

    logic is_com;
    logic com_in_search;
    logic take_data;
    logic group_done;
    logic realign;

    assign is_com        = (data_in == COM_SYM);
    assign com_in_search = valid_in && (state_reg == SEARCH) && is_com;

`ifdef PHY_RX_COM_STRIP_EN
    // While aligned, a COM is stripped and resynchronises the lane counter.
    assign realign   = valid_in && (state_reg == ALIGNED) && is_com;
    assign take_data = valid_in && (state_reg == ALIGNED) && !is_com;
`else
    assign realign   = 1'b0;
    assign take_data = valid_in && (state_reg == ALIGNED);
`endif

    assign group_done = take_data && (lane_idx_reg == LANES_W'(LANES - 1));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state_reg <= SEARCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    // Once aligned we stay aligned; only reset returns to SEARCH.
    always_comb begin
        state_next = state_reg;
        if (com_in_search) begin
            state_next = ALIGNED;
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        aligned = 1'b0;
        if (state_reg == ALIGNED) begin
            aligned = 1'b1;
        end
    end

    // ---------------- Lane counter ----------------
    // LANES is a power of two, so the natural wrap of lane_idx_reg gives
    // the modulo-4 increment.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            lane_idx_reg <= '0;
        end else if (com_in_search || realign) begin
            lane_idx_reg <= '0;
        end else if (take_data) begin
            lane_idx_reg <= lane_idx_reg + 1'b1;
        end
    end

    // ---------------- Staging for lanes 0..2 ----------------
    // The lane-3 byte goes straight to the output register, so only the first
    // three bytes need staging. A dropped partial group needs no clearing:
    // its bytes are overwritten before the next group can complete.
    generate
        for (genvar gi = 0; gi < LANES - 1; gi++) begin : g_stage
            always_ff @(posedge clk) begin
                if (!reset_L) begin
                    stage_reg[gi] <= 8'h00;
                end else if (take_data && (lane_idx_reg == LANES_W'(gi))) begin
                    stage_reg[gi] <= data_in;
                end
            end
        end
    endgenerate

    // ---------------- Output registers ----------------
    // All four outputs update together on the lane-3 edge, so the group
    // appears one cycle after its last byte is accepted.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_out
            if (gi < LANES - 1) begin : g_staged
                always_ff @(posedge clk) begin
                    if (!reset_L) begin
                        out_reg[gi] <= 8'h00;
                    end else if (group_done) begin
                        out_reg[gi] <= stage_reg[gi];
                    end
                end
            end else begin : g_direct
                always_ff @(posedge clk) begin
                    if (!reset_L) begin
                        out_reg[gi] <= 8'h00;
                    end else if (group_done) begin
                        out_reg[gi] <= data_in;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            valid_out_reg <= 1'b0;
        end else begin
            valid_out_reg <= group_done;
        end
    end

    assign data_out0 = out_reg[0];
    assign data_out1 = out_reg[1];
    assign data_out2 = out_reg[2];
    assign data_out3 = out_reg[3];
    assign valid_out = valid_out_reg;

    // ---------------- Alignment error ----------------
`ifdef PHY_RX_COM_STRIP_EN
    logic align_err_reg;

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            align_err_reg <= 1'b0;
        end else begin
            align_err_reg <= realign && (lane_idx_reg != '0);
        end
    end

    assign align_err = align_err_reg;
`else
    assign align_err = 1'b0;
`endif

endmodule

// File: tb/tb_phy_rx_destripe.sv
module tb_phy_rx_destripe;

    logic       clk;
    logic       reset_L;
    logic [7:0] data_in;
    logic       valid_in;
    logic [7:0] data_out0, data_out1, data_out2, data_out3;
    logic       valid_out;
    logic       aligned;
    logic       align_err;

    int checks   = 0;
    int failures = 0;

    // Expected groups, packed {lane3, lane2, lane1, lane0}.
    logic [31:0] exp_q[$];

    int cyc      = 0;
    int last_vo  = -1;
    int prev_vo  = -1;
    int err_cnt  = 0;

    phy_rx_destripe dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .data_out0 (data_out0),
        .data_out1 (data_out1),
        .data_out2 (data_out2),
        .data_out3 (data_out3),
        .valid_out (valid_out),
        .aligned   (aligned),
        .align_err (align_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end else begin
            $display("ok   %s value=%h", name, act);
        end
    endtask

    // Monitor: pops an expected group whenever the DUT presents one.
    always @(negedge clk) begin
        cyc++;
        if (align_err === 1'b1) err_cnt++;
        if (valid_out === 1'b1) begin
            prev_vo = last_vo;
            last_vo = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_valid_out", {data_out3, data_out2, data_out1, data_out0}, 32'hxxxx_xxxx);
            end else begin
                check("group", {data_out3, data_out2, data_out1, data_out0}, exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic [7:0] b);
        data_in  = b;
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_L  = 1'b0;
        valid_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_L = 1'b1;
    endtask

    initial begin
        reset_L  = 1'b0;
        valid_in = 1'b0;
        data_in  = 8'h00;

        // Reset state
        do_reset();
        check("rst_data_out", {data_out3, data_out2, data_out1, data_out0}, 32'h0);
        check("rst_valid_out", 32'(valid_out), 32'd0);
        check("rst_aligned", 32'(aligned), 32'd0);
        check("rst_align_err", 32'(align_err), 32'd0);

        // Basic group
        exp_q.push_back(32'h04030201);
        send(8'hBC); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        idle(1);
        check("basic_aligned", 32'(aligned), 32'd1);
        idle(5);
        check("hold_data_out", {data_out3, data_out2, data_out1, data_out0}, 32'h04030201);

        // Bytes before COM are discarded
        do_reset();
        send(8'h11); send(8'h22);
        idle(2);
        check("precom_aligned", 32'(aligned), 32'd0);
        exp_q.push_back(32'hDDCCBBAA);
        send(8'hBC); send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
        idle(3);

        // Pause mid-group
        do_reset();
        exp_q.push_back(32'h04030201);
        send(8'hBC); send(8'h01); send(8'h02);
        idle(3);
        send(8'h03); send(8'h04);
        idle(3);

        // COM inside an aligned stream
        do_reset();
        err_cnt = 0;
`ifdef PHY_RX_COM_STRIP_EN
        exp_q.push_back(32'h08070605);
        send(8'hBC); send(8'h01); send(8'h02); send(8'hBC);
        send(8'h05); send(8'h06); send(8'h07); send(8'h08);
        idle(3);
        check("align_err_pulses", 32'(err_cnt), 32'd1);
`else
        exp_q.push_back(32'h0403BC01);
        send(8'hBC); send(8'h01); send(8'hBC); send(8'h03); send(8'h04);
        idle(3);
        check("align_err_pulses", 32'(err_cnt), 32'd0);
`endif

        // Reset mid-group, with a byte presented during reset
        do_reset();
        send(8'hBC); send(8'h01); send(8'h02);
        reset_L  = 1'b0;
        data_in  = 8'h03;
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        reset_L = 1'b1;
        check("midrst_aligned", 32'(aligned), 32'd0);
        check("midrst_data_out", {data_out3, data_out2, data_out1, data_out0}, 32'h0);
        send(8'h03); send(8'h04); send(8'h05); send(8'h06);
        idle(3);
        check("postrst_aligned", 32'(aligned), 32'd0);
        exp_q.push_back(32'h44332211);
        send(8'hBC); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        idle(3);

        // Back-to-back groups, no bubble
        do_reset();
        exp_q.push_back(32'hA3A2A1A0);
        exp_q.push_back(32'hB3B2B1B0);
        send(8'hBC);
        send(8'hA0); send(8'hA1); send(8'hA2); send(8'hA3);
        send(8'hB0); send(8'hB1); send(8'hB2); send(8'hB3);
        idle(3);
        check("b2b_spacing", 32'(last_vo - prev_vo), 32'd4);

        idle(5);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
